relay_rx_deframer: RTL and testbench

Receive-side framer for the Proxmark-to-Proxmark relay link. It samples the serial data_in line at the relay bit rate, hunts for the sync nibble, and parses a length nibble followed by odd-parity bytes. Received bytes go into a small FIFO. The SSP/ARM-facing relay stage drains that FIFO with a valid/ready handshake.

---
 rtl/relay_rx_deframer.sv | 242 ++++++++++++++++++++++++
 tb/tb_relay_rx_deframer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relay_rx_deframer.sv
// relay_rx_deframer
//   Receive-side deframer for the Proxmark-to-Proxmark relay link. The serial
//   line is sampled once per bit period (16 clocks). The deframer hunts for the
//   sync nibble and reads a length nibble. It then parses that many bytes, each
//   sent as 8 data bits followed by an odd-parity bit. Each byte and its
//   parity-error flag go into a small FIFO. The relay stage drains that FIFO
//   with a valid/ready handshake.
//
// Ports
//   ck_1356meg    in   13.56 MHz clock, all logic on the rising edge
//   reset         in   synchronous, active-high
//   enable        in   0 holds the deframer in HUNT (FIFO keeps its contents)
//   data_in       in   asynchronous serial line from the remote Proxmark
//   byte_out      out  FIFO head data byte (0 while the FIFO is empty)
//   byte_perr     out  FIFO head parity-error flag
//   byte_valid    out  FIFO non-empty
//   byte_ready    in   consumer takes the head when byte_valid is high
//   frame_start   out  1-cycle pulse when the sync nibble is detected
//   frame_end     out  1-cycle pulse with the push of the last byte of a frame
//   len_err       out  1-cycle pulse when the length nibble is zero
//   overflow      out  sticky flag, set by a push that finds the FIFO full
//   overflow_clr  in   clears overflow (a set in the same cycle wins)
module relay_rx_deframer #(
    parameter logic [3:0] SYNC_WORD  = 4'hA,
    parameter int         FIFO_DEPTH = 4,
    parameter int         FIFO_AW    = 2
) (
    input  logic       ck_1356meg,
    input  logic       reset,
    input  logic       enable,
    input  logic       data_in,
    output logic [7:0] byte_out,
    output logic       byte_perr,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_start,
    output logic       frame_end,
    output logic       len_err,
    output logic       overflow,
    input  logic       overflow_clr
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LEN    = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_t;

    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input synchroniser and bit-rate timing
    // ------------------------------------------------------------------
    logic       sync_ff1;
    logic       sync_ff2;
    logic [2:0] div;
    logic       phase;
    logic       tick;
    logic       sample;
    logic       rx_bit;

    // NOTE: clocked state is assigned with <= so every flop samples the
    // pre-edge value of its neighbours; a blocking = here would let sync_ff2
    // see this cycle's sync_ff1 and collapse the two-stage synchroniser.
    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
            div      <= 3'd0;
            phase    <= 1'b0;
        end else begin
            sync_ff1 <= data_in;
            sync_ff2 <= sync_ff1;
            div      <= div + 3'd1;
            if (tick) begin
                phase <= ~phase;
            end
        end
    end

    // The tick comes every 8 clocks. Only every other tick is a bit sample.
    assign tick   = (div == 3'b100);
    assign sample = tick & ~phase & ~reset;
    assign rx_bit = sync_ff2;

    // ------------------------------------------------------------------
    // Frame parser FSM
    // ------------------------------------------------------------------
    state_t     state,     state_n;
    logic [3:0] hunt_sr,   hunt_n;
    logic [3:0] len_sr,    len_n;
    logic [2:0] bit_cnt,   bit_cnt_n;
    logic [7:0] data_sr,   data_n;
    logic [3:0] remaining, remaining_n;
    logic       push;
    logic [8:0] push_word;

    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            state     <= HUNT;
            hunt_sr   <= 4'd0;
            len_sr    <= 4'd0;
            bit_cnt   <= 3'd0;
            data_sr   <= 8'd0;
            remaining <= 4'd0;
        end else begin
            state     <= state_n;
            hunt_sr   <= hunt_n;
            len_sr    <= len_n;
            bit_cnt   <= bit_cnt_n;
            data_sr   <= data_n;
            remaining <= remaining_n;
        end
    end

    // NOTE: every signal driven here gets a default before the case
    // statement, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        hunt_n      = hunt_sr;
        len_n       = len_sr;
        bit_cnt_n   = bit_cnt;
        data_n      = data_sr;
        remaining_n = remaining;
        push        = 1'b0;
        push_word   = {1'b0, data_sr};
        frame_start = 1'b0;
        frame_end   = 1'b0;
        len_err     = 1'b0;

        if (!enable) begin
            state_n   = HUNT;
            hunt_n    = 4'd0;
            bit_cnt_n = 3'd0;
        end else if (sample) begin
            unique case (state)
                HUNT: begin
                    hunt_n = {hunt_sr[2:0], rx_bit};
                    if (hunt_n == SYNC_WORD) begin
                        frame_start = 1'b1;
                        bit_cnt_n   = 3'd0;
                        state_n     = LEN;
                    end
                end
                LEN: begin
                    len_n     = {len_sr[2:0], rx_bit};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd3) begin
                        bit_cnt_n = 3'd0;
                        if (len_n == 4'd0) begin
                            len_err = 1'b1;
                            hunt_n  = 4'd0;
                            state_n = HUNT;
                        end else begin
                            remaining_n = len_n;
                            state_n     = DATA;
                        end
                    end
                end
                DATA: begin
                    data_n    = {data_sr[6:0], rx_bit};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = 3'd0;
                        state_n   = PARITY;
                    end
                end
                PARITY: begin
                    // The 9 bits must have odd parity. Even parity flags an error.
                    push        = 1'b1;
                    push_word   = {~(^{data_sr, rx_bit}), data_sr};
                    remaining_n = remaining - 4'd1;
                    if (remaining == 4'd1) begin
                        frame_end = 1'b1;
                        hunt_n    = 4'd0;
                        state_n   = HUNT;
                    end else begin
                        state_n = DATA;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [8:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               pop;
    logic               push_ok;

    assign full       = (count == FULL_COUNT);
    assign byte_valid = (count != '0);
    assign pop        = byte_valid & byte_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push & (~full | pop);

    assign byte_out  = byte_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign byte_perr = byte_valid ? mem[rd_ptr][8]   : 1'b0;

    // NOTE: the storage array has no reset. An entry is only read after a
    // push has written it, and byte_out/byte_perr are masked while the FIFO
    // is empty.
    always_ff @(posedge ck_1356meg) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relay_rx_deframer.sv
// tb_relay_rx_deframer
//   Directed-vector bench for relay_rx_deframer. Frames are sent one bit per
//   16 clocks. A reference model runs each clock. It parses the sampled bit
//   stream by bit position within the frame and keeps the expected FIFO as a
//   queue. The FIFO head, valid, overflow and the three pulses are compared
//   against the model on every clock. Hand-computed byte sequences and pulse
//   counts are checked after each scenario.
module tb_relay_rx_deframer;

    localparam logic [3:0] SYNC = 4'hA;
    localparam int         DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] byte_out;
    logic       byte_perr;
    logic       byte_valid;
    logic       byte_ready = 1'b1;
    logic       frame_start;
    logic       frame_end;
    logic       len_err;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    relay_rx_deframer dut (
        .ck_1356meg  (clk),
        .reset       (reset),
        .enable      (enable),
        .data_in     (data_in),
        .byte_out    (byte_out),
        .byte_perr   (byte_perr),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .len_err     (len_err),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Clocks since the last edge that saw reset high.
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [8:0] m_fifo [$];
    logic       m_ov;
    logic       m_h1, m_h2;       // data_in seen one and two clocks ago
    logic       m_in_frame;
    logic [3:0] m_hunt;
    int         m_bits [$];       // bits received since the sync nibble
    int         m_len;

    logic [8:0] pop_log [$];      // what the DUT presented on each pop
    logic [8:0] exp_log [$];
    int         fs_cnt, fe_cnt, le_cnt;

    task automatic model_step(input logic b, output logic fs, output logic fe,
                              output logic le, output logic pv, output logic [8:0] w);
        int n, val, ones;
        fs = 1'b0; fe = 1'b0; le = 1'b0; pv = 1'b0; w = '0;
        if (!m_in_frame) begin
            m_hunt = {m_hunt[2:0], b};
            if (m_hunt == SYNC) begin
                fs = 1'b1;
                m_in_frame = 1'b1;
                m_bits.delete();
            end
        end else begin
            m_bits.push_back(int'(b));
            n = m_bits.size();
            if (n == 4) begin
                m_len = m_bits[0] * 8 + m_bits[1] * 4 + m_bits[2] * 2 + m_bits[3];
                if (m_len == 0) begin
                    le = 1'b1;
                    m_in_frame = 1'b0;
                    m_hunt = 4'd0;
                end
            end else if (n > 4 && (n - 4) % 9 == 0) begin
                // The last 9 bits are one byte, MSB first, then its parity bit.
                val = 0;
                ones = 0;
                for (int i = 0; i < 8; i++) begin
                    val = val * 2 + m_bits[n - 9 + i];
                    ones += m_bits[n - 9 + i];
                end
                ones += m_bits[n - 1];
                w  = {logic'(ones % 2 == 0), 8'(val)};
                pv = 1'b1;
                if ((n - 4) / 9 == m_len) begin
                    fe = 1'b1;
                    m_in_frame = 1'b0;
                    m_hunt = 4'd0;
                end
            end
        end
    endtask

    // Compare process: one pass per clock, on the falling edge.
    always @(negedge clk) begin
        logic       b, fs, fe, le, pv, pop, exp_valid;
        logic [8:0] w, exp_head;
        if (reset) begin
            m_fifo.delete();
            m_ov = 1'b0;
            m_h1 = 1'b0;
            m_h2 = 1'b0;
            m_in_frame = 1'b0;
            m_hunt = 4'd0;
        end else begin
            exp_valid = (m_fifo.size() != 0);
            exp_head  = exp_valid ? m_fifo[0] : 9'h000;
            check("byte_valid", 32'(byte_valid), 32'(exp_valid));
            check("head", 32'({byte_perr, byte_out}), 32'(exp_head));
            check("overflow", 32'(overflow), 32'(m_ov));

            b = m_h2;
            m_h2 = m_h1;
            m_h1 = data_in;
            fs = 1'b0; fe = 1'b0; le = 1'b0; pv = 1'b0; w = '0;
            if (!enable) begin
                m_in_frame = 1'b0;
                m_hunt = 4'd0;
            end else if (cyc % 16 == 4) begin
                model_step(b, fs, fe, le, pv, w);
            end
            check("frame_start", 32'(frame_start), 32'(fs));
            check("frame_end", 32'(frame_end), 32'(fe));
            check("len_err", 32'(len_err), 32'(le));
            if (frame_start) fs_cnt++;
            if (frame_end)   fe_cnt++;
            if (len_err)     le_cnt++;

            pop = exp_valid && byte_ready;
            if (pop) begin
                pop_log.push_back({byte_perr, byte_out});
                void'(m_fifo.pop_front());
            end
            if (pv && m_fifo.size() >= DEPTH) begin
                m_ov = 1'b1;
            end else begin
                if (pv) m_fifo.push_back(w);
                if (overflow_clr) m_ov = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Move to the point 8 clocks before a sample, so each bit is stable
    // well before and after it is sampled.
    task automatic align();
        tick1();
        while (cyc % 16 != 12) tick1();
    endtask

    task automatic send_bit(input logic b, input logic ready_pulse);
        data_in = b;
        if (ready_pulse) begin
            repeat (8) tick1();
            byte_ready = 1'b1;       // high during the sample cycle of this bit
            tick1();
            byte_ready = 1'b0;
            repeat (7) tick1();
        end else begin
            repeat (16) tick1();
        end
    endtask

    task automatic send_header(input logic [3:0] len);
        align();
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) send_bit(SYNC[i], 1'b0);
        for (int i = 3; i >= 0; i--) send_bit(len[i], 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] val, input logic flip, input logic ready_pulse);
        for (int i = 7; i >= 0; i--) send_bit(val[i], 1'b0);
        send_bit(~(^val) ^ flip, ready_pulse);
    endtask

    task automatic idle();
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
    endtask

    task automatic expect_byte(input logic [8:0] w);
        exp_log.push_back(w);
    endtask

    task automatic check_log(input string name);
        check({name, " pop count"}, 32'(pop_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < pop_log.size(); i++)
            check({name, " pop data"}, 32'(pop_log[i]), 32'(exp_log[i]));
        pop_log.delete();
        exp_log.delete();
    endtask

    task automatic clear_counts();
        fs_cnt = 0;
        fe_cnt = 0;
        le_cnt = 0;
        pop_log.delete();
        exp_log.delete();
    endtask

    task automatic do_reset();
        tick1();
        reset = 1'b1;
        repeat (2) tick1();
        reset = 1'b0;
        tick1();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick1();
        check("reset byte_valid", 32'(byte_valid), 32'd0);
        check("reset head", 32'({byte_perr, byte_out}), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset pulses", 32'({frame_start, frame_end, len_err}), 32'd0);

        // 1: two good bytes
        clear_counts();
        send_header(4'd2);
        send_byte(8'h5A, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        idle();
        expect_byte(9'h05A);
        expect_byte(9'h0C3);
        check_log("t1");
        check("t1 frame_start count", 32'(fs_cnt), 32'd1);
        check("t1 frame_end count", 32'(fe_cnt), 32'd1);
        check("t1 overflow", 32'(overflow), 32'd0);

        // 2: parity error on the first byte
        clear_counts();
        send_header(4'd2);
        send_byte(8'h5A, 1'b1, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        idle();
        expect_byte(9'h15A);
        expect_byte(9'h0C3);
        check_log("t2");
        check("t2 frame_end count", 32'(fe_cnt), 32'd1);

        // 3: zero length, then a one-byte frame
        clear_counts();
        send_header(4'd0);
        idle();
        check("t3 len_err count", 32'(le_cnt), 32'd1);
        check("t3 frame_start count", 32'(fs_cnt), 32'd1);
        check("t3 fifo empty", 32'(byte_valid), 32'd0);
        send_header(4'd1);
        send_byte(8'hFF, 1'b0, 1'b0);
        idle();
        expect_byte(9'h0FF);
        check_log("t3");
        check("t3 frame_end count", 32'(fe_cnt), 32'd1);

        // 4: consumer stalled, six bytes into a 4-deep FIFO
        clear_counts();
        byte_ready = 1'b0;
        send_header(4'd6);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h66, 1'b0, 1'b0);
        idle();
        check("t4 byte_valid", 32'(byte_valid), 32'd1);
        check("t4 overflow set", 32'(overflow), 32'd1);
        check("t4 frame_end count", 32'(fe_cnt), 32'd1);
        byte_ready = 1'b1;
        repeat (10) tick1();
        expect_byte(9'h011);
        expect_byte(9'h022);
        expect_byte(9'h033);
        expect_byte(9'h044);
        check_log("t4");
        check("t4 overflow sticky", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        tick1();
        overflow_clr = 1'b0;
        check("t4 overflow cleared", 32'(overflow), 32'd0);

        // 5: FIFO full, consumer pops on exactly the fifth push
        clear_counts();
        byte_ready = 1'b0;
        send_header(4'd5);
        send_byte(8'hA1, 1'b0, 1'b0);
        send_byte(8'hB2, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        send_byte(8'hD4, 1'b0, 1'b0);
        send_byte(8'hE5, 1'b0, 1'b1);
        idle();
        check("t5 overflow", 32'(overflow), 32'd0);
        check("t5 byte_valid", 32'(byte_valid), 32'd1);
        byte_ready = 1'b1;
        repeat (10) tick1();
        expect_byte(9'h0A1);
        expect_byte(9'h0B2);
        expect_byte(9'h0C3);
        expect_byte(9'h0D4);
        expect_byte(9'h0E5);
        check_log("t5");

        // 6a: reset during the data bits of the first byte, with an entry queued
        byte_ready = 1'b0;
        send_header(4'd1);
        send_byte(8'h77, 1'b0, 1'b0);
        idle();
        check("t6a queued", 32'(byte_valid), 32'd1);
        clear_counts();
        send_header(4'd2);
        for (int i = 7; i >= 4; i--) send_bit(8'h3C >> i, 1'b0);
        data_in = 1'b0;
        do_reset();
        check("t6a flushed", 32'(byte_valid), 32'd0);
        check("t6a frame_end count", 32'(fe_cnt), 32'd0);
        byte_ready = 1'b1;
        send_header(4'd1);
        send_byte(8'h96, 1'b0, 1'b0);
        idle();
        expect_byte(9'h096);
        check_log("t6a");
        check("t6a frame_end after", 32'(fe_cnt), 32'd1);

        // 6b: enable dropped during the data bits of the first byte
        clear_counts();
        send_header(4'd2);
        for (int i = 7; i >= 4; i--) send_bit(8'h3C >> i, 1'b0);
        data_in = 1'b0;
        enable = 1'b0;
        repeat (40) tick1();
        check("t6b no push", 32'(byte_valid), 32'd0);
        enable = 1'b1;
        send_header(4'd1);
        send_byte(8'h69, 1'b0, 1'b0);
        idle();
        expect_byte(9'h069);
        check_log("t6b");
        check("t6b frame_end count", 32'(fe_cnt), 32'd1);
        check("t6b frame_start count", 32'(fs_cnt), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
